// File: rtl/cache_pkg.sv
// Shared state encoding and set-index helper for the cache request controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } ctrl_state_t;

  // Low address bits select the set; sets must be a power of two.
  function automatic int unsigned set_index(input logic [31:0] addr, input int unsigned sets);
    return addr & (sets - 1);
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Bundles the CPU, set-array and backing-memory buses of the cache controller.
interface cache_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int SETS       = 4
);

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [ADDR_WIDTH-1:0]      req_addr;
  logic [LINE_WIDTH-1:0]      req_wdata;
  logic                       rsp_valid;
  logic [LINE_WIDTH-1:0]      rsp_data;

  logic [SETS-1:0]            set_enable;
  logic                       set_read;
  logic                       set_write;
  logic [ADDR_WIDTH-1:0]      set_addr;
  logic [LINE_WIDTH-1:0]      set_val;
  logic [SETS-1:0]            set_hit;
  logic [SETS*LINE_WIDTH-1:0] set_out_val;

  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic                       mem_write;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [LINE_WIDTH-1:0]      mem_wdata;
  logic                       mem_rsp_valid;
  logic [LINE_WIDTH-1:0]      mem_rsp_data;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data,
    output set_enable, set_read, set_write, set_addr, set_val,
    input  set_hit, set_out_val,
    output mem_req_valid, mem_write, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data,
    input  set_enable, set_read, set_write, set_addr, set_val,
    output set_hit, set_out_val,
    input  mem_req_valid, mem_write, mem_addr, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/cache_ctrl.sv
// Single-outstanding request controller in front of the K-way set array;
// write-through, write-allocate, misses refilled from backing memory.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int SETS       = 4,
  parameter int K          = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  cache_ctrl_if.master bus
);

  localparam int IDX_W    = $clog2(SETS);
  localparam int FILL_MAX = K + 2;
  localparam int CNT_W    = $clog2(FILL_MAX + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [LINE_WIDTH-1:0] line_t;

  ctrl_state_t      state, state_next;
  logic             active;
  logic             write_q;
  addr_t            addr_q;
  line_t            wdata_q;
  line_t            set_val_q;
  line_t            rsp_data_q;
  logic [CNT_W-1:0] fill_cnt;

  logic [IDX_W-1:0] idx;
  logic             hit_sel;
  line_t            hit_data;
  logic             ready_int;
  logic             accept;

  assign idx       = IDX_W'(set_index(32'(addr_q), SETS));
  assign hit_sel   = bus.set_hit[idx];
  assign hit_data  = bus.set_out_val[idx*LINE_WIDTH +: LINE_WIDTH];
  // active keeps req_ready low while reset is held and until the first clock after release.
  assign ready_int = active && (state == IDLE);
  assign accept    = ready_int && bus.req_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    bus.req_ready      = ready_int;
    bus.rsp_valid      = 1'b0;
    bus.set_enable     = '0;
    bus.set_read       = 1'b0;
    bus.set_write      = 1'b0;
    bus.mem_req_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = bus.req_write ? MEM_REQ : LOOKUP;
        end
      end
      LOOKUP: begin
        bus.set_enable = SETS'(1) << idx;
        bus.set_read   = 1'b1;
        state_next     = CHECK;
      end
      CHECK: begin
        bus.set_enable = SETS'(1) << idx;
        state_next     = hit_sel ? RESP : MEM_REQ;
      end
      MEM_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_next = FILL;
        end
      end
      FILL: begin
        bus.set_enable = SETS'(1) << idx;
        bus.set_write  = 1'b1;
        // set_hit during the first FILL cycle predates the write, so only later cycles count.
        if ((fill_cnt != '0) && hit_sel) begin
          state_next = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      set_val_q  <= '0;
      rsp_data_q <= '0;
      fill_cnt   <= '0;
    end else begin
      active <= 1'b1;
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if ((state == CHECK) && hit_sel) begin
        rsp_data_q <= hit_data;
      end
      if ((state == MEM_WAIT) && bus.mem_rsp_valid) begin
        if (write_q) begin
          set_val_q  <= wdata_q;
          rsp_data_q <= wdata_q;
        end else begin
          set_val_q  <= bus.mem_rsp_data;
          rsp_data_q <= bus.mem_rsp_data;
        end
      end
      fill_cnt <= (state == FILL) ? fill_cnt + 1'b1 : '0;
    end
  end

  assign bus.set_addr  = addr_q;
  assign bus.set_val   = set_val_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mem_write = write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // CLOCK eviction sweeps at most every way once before installing.
  fill_bound_a: assert property (
    @(posedge clock) disable iff (!reset_n)
    (state == FILL) |-> (fill_cnt < CNT_W'(FILL_MAX))
  );

endmodule
